// File: rtl/sprite_motion_ctrl.sv
// Sprite position generator: a tick divider plus one motion unit per screen
// axis (wrap / clamp / bounce / freeze). Positions are the sprite's top-left.

// One axis of motion. Holds the axis position and bounce direction and moves
// them on each update strobe. hit_req is the combinational wall/clamp flag for
// the pending update; the top registers it.
module sprite_axis #(
    parameter int W     = 12,
    parameter int MAX   = 775,
    parameter int START = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         upd,
    input  logic         inc,
    input  logic         dec,
    input  logic [1:0]   mode,
    input  logic [2:0]   speed,
    output logic [W-1:0] pos,
    output logic         dir,
    output logic         hit_req
);
    localparam logic signed [15:0] MX = 16'(MAX);

    logic signed [15:0] p, s, step, t, n;
    logic               mv, d;

    assign p  = $signed({{(16-W){1'b0}}, pos});
    assign s  = $signed({13'b0, speed});
    assign mv = inc ^ dec;

    // Next position/dir/hit for this axis; 16-bit signed so no step can truncate.
    always_comb begin
        step    = mv ? (inc ? s : -s) : 16'sd0;
        t       = p;
        n       = p;
        d       = dir;
        hit_req = 1'b0;
        case (mode)
            2'd0: begin
                t = p + step;
                if (t > MX)           n = t - (MX + 16'sd1);
                else if (t < 16'sd0)  n = t + (MX + 16'sd1);
                else                  n = t;
            end
            2'd1: begin
                t = p + step;
                if (t > MX)           n = MX;
                else if (t < 16'sd0)  n = 16'sd0;
                else                  n = t;
                hit_req = (t > MX) || (t < 16'sd0);
            end
            2'd2: begin
                // a single pressed button steers the bounce before it moves
                if (mv) d = dec;
                t = d ? (p - s) : (p + s);
                if (t > MX) begin
                    n       = 16'sd2 * MX - t;
                    d       = ~d;
                    hit_req = 1'b1;
                end else if (t < 16'sd0) begin
                    n       = -t;
                    d       = ~d;
                    hit_req = 1'b1;
                end else begin
                    n = t;
                end
            end
            default: ;
        endcase
    end

    // Position/dir register, only moves on the update strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos <= W'(START);
            dir <= 1'b0;
        end else if (upd) begin
            pos <= n[W-1:0];
            dir <= d;
        end
    end
endmodule

module sprite_motion_ctrl #(
    parameter int HOR_FIELD = 800,
    parameter int VER_FIELD = 600,
    parameter int SIZE      = 25,
    parameter int TICK_DIV  = 1048576,
    parameter int START_H   = 0,
    parameter int START_V   = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  control,
    input  logic [1:0]  mode,
    input  logic [2:0]  speed,
    output logic [11:0] hor_pos,
    output logic [10:0] ver_pos,
    output logic        dir_h,
    output logic        dir_v,
    output logic        tick,
    output logic        hit
);
    localparam int HMAX = HOR_FIELD - SIZE;
    localparam int VMAX = VER_FIELD - SIZE;
    localparam int CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CLAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] counter;
    logic          hit_h, hit_v;

    // Free-running divider; tick is the registered terminal-count strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= '0;
            tick    <= 1'b0;
        end else begin
            counter <= (counter == CLAST) ? '0 : counter + 1'b1;
            tick    <= (counter == CLAST);
        end
    end

    // x axis: right = +x, left = -x
    sprite_axis #(.W(12), .MAX(HMAX), .START(START_H)) u_ax_h (
        .clock(clock), .reset(reset), .upd(tick),
        .inc(control[3]), .dec(control[1]),
        .mode(mode), .speed(speed),
        .pos(hor_pos), .dir(dir_h), .hit_req(hit_h)
    );

    // y axis: down = +y, up = -y
    sprite_axis #(.W(11), .MAX(VMAX), .START(START_V)) u_ax_v (
        .clock(clock), .reset(reset), .upd(tick),
        .inc(control[2]), .dec(control[0]),
        .mode(mode), .speed(speed),
        .pos(ver_pos), .dir(dir_v), .hit_req(hit_v)
    );

    // hit is a one-cycle pulse following an update that reflected or clamped.
    always_ff @(posedge clock) begin
        if (reset) hit <= 1'b0;
        else       hit <= tick & (hit_h | hit_v);
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed scenarios plus random stimulus,
// everything compared against a cycle-level behavioural model.
module tb_sprite_motion_ctrl;
    localparam int TD   = 4;
    localparam int HMAX = 775;
    localparam int VMAX = 575;

    logic        clock, reset;
    logic [3:0]  control;
    logic [1:0]  mode;
    logic [2:0]  speed;
    logic [11:0] hor_pos;
    logic [10:0] ver_pos;
    logic        dir_h, dir_v, tick, hit;

    sprite_motion_ctrl #(.HOR_FIELD(800), .VER_FIELD(600), .SIZE(25),
                         .TICK_DIV(TD), .START_H(0), .START_V(0)) dut (
        .clock(clock), .reset(reset), .control(control), .mode(mode),
        .speed(speed), .hor_pos(hor_pos), .ver_pos(ver_pos),
        .dir_h(dir_h), .dir_v(dir_v), .tick(tick), .hit(hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int m_h, m_v, k;
    bit m_dh, m_dv, m_tick, m_hit, upd;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One axis moved by the rules of the current mode, in plain integers.
    task automatic model_axis(input int pos, input bit plus, input bit minus,
                              input bit dir, input int md, input int s, input int mx,
                              output int np, output bit nd, output bit h);
        int t;
        bit move;
        move = (plus != minus);
        np = pos; nd = dir; h = 0;
        case (md)
            0: if (move) begin
                t  = pos + (plus ? s : -s);
                np = (t + mx + 1) % (mx + 1);
            end
            1: if (move) begin
                t  = pos + (plus ? s : -s);
                np = (t < 0) ? 0 : ((t > mx) ? mx : t);
                h  = (np != t);
            end
            2: begin
                if (move) nd = minus;
                t = nd ? pos - s : pos + s;
                if (t > mx)     begin np = 2*mx - t; nd = !nd; h = 1; end
                else if (t < 0) begin np = -t;       nd = !nd; h = 1; end
                else np = t;
            end
            default: ;
        endcase
    endtask

    // Advance one clock, step the model with the inputs seen at the edge,
    // then compare every output shortly after the edge.
    task automatic cycle();
        int nh, nv;
        bit dh, dv, hh, hv;
        @(posedge clock);
        upd = 0;
        if (reset) begin
            m_h = 0; m_v = 0; m_dh = 0; m_dv = 0;
            m_tick = 0; m_hit = 0; k = 0;
        end else begin
            m_hit = 0;
            if (m_tick) begin
                model_axis(m_h, control[3], control[1], m_dh, int'(mode), int'(speed), HMAX, nh, dh, hh);
                model_axis(m_v, control[2], control[0], m_dv, int'(mode), int'(speed), VMAX, nv, dv, hv);
                m_h = nh; m_v = nv; m_dh = dh; m_dv = dv;
                m_hit = hh | hv;
                upd = 1;
            end
            k++;
            m_tick = (k % TD == 0);
        end
        #1;
        chk("hor_pos", int'(hor_pos), m_h);
        chk("ver_pos", int'(ver_pos), m_v);
        chk("dir_h", int'(dir_h), int'(m_dh));
        chk("dir_v", int'(dir_v), int'(m_dv));
        chk("tick", int'(tick), int'(m_tick));
        chk("hit", int'(hit), int'(m_hit));
        chk("hor_range", int'(hor_pos <= 12'(HMAX)), 1);
        chk("ver_range", int'(ver_pos <= 11'(VMAX)), 1);
    endtask

    task automatic wait_update();
        bit got;
        got = 0;
        for (int i = 0; i < 3*TD; i++) begin
            cycle();
            if (upd) begin got = 1; break; end
        end
        if (!got) chk("update_timeout", 0, 1);
    endtask

    task automatic set_in(input logic [1:0] md, input logic [2:0] sp, input logic [3:0] ct);
        mode = md; speed = sp; control = ct;
    endtask

    initial begin
        bit seen;
        reset = 1'b1; control = '0; mode = '0; speed = '0;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_hor", int'(hor_pos), 0);
        chk("rst_ver", int'(ver_pos), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_hit", int'(hit), 0);

        // ticks on cycles TD, 2TD, 3TD after release
        for (int i = 1; i <= 12; i++) begin
            cycle();
            chk("tick_period", int'(tick), int'(i % TD == 0));
        end
        chk("idle_hor", int'(hor_pos), 0);

        // wrap through the left edge, then the spec's 774 <-> 1 case
        set_in(2'd0, 3'd1, 4'b0010);
        wait_update(); chk("wrap_l0", int'(hor_pos), 775);
        wait_update(); chk("wrap_l1", int'(hor_pos), 774);
        set_in(2'd0, 3'd3, 4'b1000);
        wait_update(); chk("wrap_r", int'(hor_pos), 1);
        chk("wrap_hit", int'(hit), 0);
        set_in(2'd0, 3'd3, 4'b0010);
        wait_update(); chk("wrap_back", int'(hor_pos), 774);

        // bring ver to 572, then clamp at the bottom wall
        set_in(2'd0, 3'd3, 4'b0001);
        wait_update(); chk("wrap_up", int'(ver_pos), 573);
        set_in(2'd0, 3'd1, 4'b0001);
        wait_update(); chk("ver_572", int'(ver_pos), 572);
        set_in(2'd1, 3'd7, 4'b0100);
        wait_update(); chk("clamp_v", int'(ver_pos), 575); chk("clamp_hit", int'(hit), 1);
        cycle();       chk("hit_pulse", int'(hit), 0);
        wait_update(); chk("clamp_v2", int'(ver_pos), 575); chk("clamp_hit2", int'(hit), 1);
        set_in(2'd1, 3'd7, 4'b0101);
        wait_update(); chk("cancel_v", int'(ver_pos), 575); chk("cancel_hit", int'(hit), 0);

        // set up hor=773, ver=2, dir_v=1 (speed 0 forces dir without motion)
        set_in(2'd0, 3'd3, 4'b0100);
        wait_update(); chk("wrap_down", int'(ver_pos), 2);
        set_in(2'd0, 3'd1, 4'b0010);
        wait_update(); chk("hor_773", int'(hor_pos), 773);
        set_in(2'd2, 3'd0, 4'b0001);
        wait_update(); chk("force_dv", int'(dir_v), 1); chk("force_hold", int'(ver_pos), 2);
        chk("force_dh", int'(dir_h), 0);

        // bounce off both walls
        set_in(2'd2, 3'd5, 4'b0000);
        wait_update();
        chk("bnc_h", int'(hor_pos), 772); chk("bnc_dh", int'(dir_h), 1);
        chk("bnc_v", int'(ver_pos), 3);   chk("bnc_dv", int'(dir_v), 0);
        chk("bnc_hit", int'(hit), 1);

        // freeze selected mid-interval, then resume bouncing with old dirs
        cycle();
        mode = 2'd3;
        wait_update(); chk("frz_h", int'(hor_pos), 772); chk("frz_v", int'(ver_pos), 3);
        wait_update(); chk("frz_h2", int'(hor_pos), 772);
        mode = 2'd2;
        wait_update();
        chk("res_h", int'(hor_pos), 767); chk("res_v", int'(ver_pos), 8);
        chk("res_dh", int'(dir_h), 1);    chk("res_dv", int'(dir_v), 0);

        // reset landing on the tick cycle suppresses the update
        seen = 0;
        for (int i = 0; i < 3*TD; i++) begin
            cycle();
            if (tick) begin seen = 1; break; end
        end
        chk("tick_seen", int'(seen), 1);
        reset = 1'b1;
        cycle();
        chk("mrst_hor", int'(hor_pos), 0); chk("mrst_ver", int'(ver_pos), 0);
        chk("mrst_dh", int'(dir_h), 0);    chk("mrst_dv", int'(dir_v), 0);
        chk("mrst_tick", int'(tick), 0);   chk("mrst_hit", int'(hit), 0);
        reset = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0)  control = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mode    = 2'($urandom);
            if ($urandom_range(0, 11) == 0) speed   = 3'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
